// File: rtl/anc2_key_driver_if.sv
// anc2_key_driver_if: host key-event handshake for the ANC-2 key driver.
//   key_valid  host -> driver  key event present
//   key_code   host -> driver  [5]=1 function key, index [3:0]; [5]=0 character, LEV code [4:0]
//   key_ready  driver -> host  accepting events (completes with key_valid)
//   key_err    driver -> host  one-cycle pulse after accepting an invalid function index
interface anc2_key_driver_if;
   logic       key_valid;
   logic [5:0] key_code;
   logic       key_ready;
   logic       key_err;

   modport master (
      output key_valid,
      output key_code,
      input  key_ready,
      input  key_err
   );

   modport slave (
      input  key_valid,
      input  key_code,
      output key_ready,
      output key_err
   );
endinterface

// File: rtl/anc2_key_driver.sv
// anc2_key_driver: typewriter key escapement emulation for the ANC-2 coupler.
// Takes one key event at a time, drives a function-key line or a LEV1..5 code for KEY_MS
// milliseconds, then locks out new events for GAP_MS milliseconds.
//   CLOCK    system clock
//   rst      synchronous reset, active-high
//   tick_ms  one-CLOCK pulse per millisecond
//   TYPE     computer typing; keyboard locked while high
//   key_if   host handshake (valid/code in, ready/err out)
//   busy     driver not idle
//   fn_key   one-hot function key lines, [0]CIR_S .. [12]F_B
//   lev      LEV1..LEV5 character code
module anc2_key_driver #(
   parameter int unsigned KEY_MS = 50,
   parameter int unsigned GAP_MS = 20,
   parameter int unsigned CNT_W  = 8
) (
   input  logic                CLOCK,
   input  logic                rst,
   input  logic                tick_ms,
   input  logic                TYPE,
   anc2_key_driver_if.slave    key_if,
   output logic                busy,
   output logic [12:0]         fn_key,
   output logic [4:0]          lev
);

   typedef enum logic [1:0] {StIdle, StHold, StGap} state_e;

   localparam logic [CNT_W-1:0] KeyThr = CNT_W'(KEY_MS);
   localparam logic [CNT_W-1:0] GapThr = CNT_W'(GAP_MS);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [12:0]      fn_key_q, fn_key_d;
   logic [4:0]       lev_q, lev_d;
   logic             key_err_q, key_err_d;
   logic             accept;
   logic             bad_fn;

   // Ready drops in the reset cycle itself so no event can slip in under rst.
   assign key_if.key_ready = (state_q == StIdle) & ~TYPE & ~rst;
   assign accept           = key_if.key_valid & key_if.key_ready;
   assign bad_fn           = key_if.key_code[5] & (key_if.key_code[3:0] > 4'd12);
   assign cnt_inc          = cnt_q + CNT_W'(1);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      fn_key_d  = fn_key_q;
      lev_d     = lev_q;
      key_err_d = 1'b0;
      case (state_q)
         StIdle: begin
            // A tick in the accept cycle is deliberately ignored.
            if (accept) begin
               if (bad_fn) begin
                  key_err_d = 1'b1;
               end else begin
                  if (key_if.key_code[5]) begin
                     fn_key_d = 13'd1 << key_if.key_code[3:0];
                     lev_d    = '0;
                  end else begin
                     fn_key_d = '0;
                     lev_d    = key_if.key_code[4:0];
                  end
                  cnt_d   = '0;
                  state_d = StHold;
               end
            end
         end
         StHold: begin
            if (tick_ms) begin
               if (cnt_inc == KeyThr) begin
                  fn_key_d = '0;
                  lev_d    = '0;
                  cnt_d    = '0;
                  state_d  = (GAP_MS == 0) ? StIdle : StGap;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         StGap: begin
            if (tick_ms) begin
               if (cnt_inc == GapThr) begin
                  cnt_d   = '0;
                  state_d = StIdle;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         default: begin
            state_d  = StIdle;
            cnt_d    = '0;
            fn_key_d = '0;
            lev_d    = '0;
         end
      endcase
   end

   always_ff @(posedge CLOCK) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         fn_key_q  <= '0;
         lev_q     <= '0;
         key_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         fn_key_q  <= fn_key_d;
         lev_q     <= lev_d;
         key_err_q <= key_err_d;
      end
   end

   assign busy           = (state_q != StIdle);
   assign fn_key         = fn_key_q;
   assign lev            = lev_q;
   assign key_if.key_err = key_err_q;

endmodule

// File: tb/tb_anc2_key_driver.sv
// tb_anc2_key_driver: directed and random checks of anc2_key_driver against a
// millisecond-countdown reference model. Two builds run side by side on the same
// stimulus: the default one and a short KEY_MS=3, GAP_MS=0 one.
module tb_anc2_key_driver;

   logic        clk = 1'b0;
   logic        rst, tick_ms, type_in;
   logic        busy0, busy1;
   logic [12:0] fn0, fn1;
   logic [4:0]  lev0, lev1;

   always #5 clk = ~clk;

   anc2_key_driver_if if0 ();
   anc2_key_driver_if if1 ();

   anc2_key_driver dut0 (
      .CLOCK   (clk),
      .rst     (rst),
      .tick_ms (tick_ms),
      .TYPE    (type_in),
      .key_if  (if0),
      .busy    (busy0),
      .fn_key  (fn0),
      .lev     (lev0)
   );

   anc2_key_driver #(
      .KEY_MS (3),
      .GAP_MS (0),
      .CNT_W  (4)
   ) dut1 (
      .CLOCK   (clk),
      .rst     (rst),
      .tick_ms (tick_ms),
      .TYPE    (type_in),
      .key_if  (if1),
      .busy    (busy1),
      .fn_key  (fn1),
      .lev     (lev1)
   );

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: a key is a number of milliseconds still to hold, then still to wait.
   typedef struct {
      int          hold_left;
      int          gap_left;
      logic [12:0] fn;
      logic [4:0]  lev;
      logic        err;
   } model_t;

   model_t m0, m1;

   function automatic logic m_idle(model_t m);
      return (m.hold_left == 0) && (m.gap_left == 0);
   endfunction

   function automatic logic m_ready(model_t m, logic r, logic ty);
      return m_idle(m) && !ty && !r;
   endfunction

   function automatic model_t m_step(model_t m, int key_ms, int gap_ms, logic r, logic tk,
                                     logic ty, logic v, logic [5:0] code);
      model_t n = m;
      int     idx;
      if (r) begin
         n.hold_left = 0;
         n.gap_left  = 0;
         n.fn        = '0;
         n.lev       = '0;
         n.err       = 1'b0;
         return n;
      end
      n.err = 1'b0;
      if (m_idle(m)) begin
         if (v && m_ready(m, r, ty)) begin
            idx = int'(code[3:0]);
            if (code[5] && idx > 12) begin
               n.err = 1'b1;
            end else begin
               n.hold_left = key_ms;
               n.fn        = '0;
               n.lev       = '0;
               if (code[5]) n.fn[idx] = 1'b1;
               else n.lev = code[4:0];
            end
         end
      end else if (m.hold_left > 0) begin
         if (tk) begin
            n.hold_left = m.hold_left - 1;
            if (n.hold_left == 0) begin
               n.fn       = '0;
               n.lev      = '0;
               n.gap_left = gap_ms;
            end
         end
      end else if (tk) begin
         n.gap_left = m.gap_left - 1;
      end
      return n;
   endfunction

   // One clock: drive at negedge, check ready before the edge, check outputs after it.
   task automatic step(input logic r, input logic tk, input logic ty, input logic v,
                       input logic [5:0] code);
      @(negedge clk);
      rst          = r;
      tick_ms      = tk;
      type_in      = ty;
      if0.key_valid = v;
      if0.key_code  = code;
      if1.key_valid = v;
      if1.key_code  = code;
      #1;
      check_eq("ready0", 32'(if0.key_ready), 32'(m_ready(m0, r, ty)));
      check_eq("ready1", 32'(if1.key_ready), 32'(m_ready(m1, r, ty)));
      m0 = m_step(m0, 50, 20, r, tk, ty, v, code);
      m1 = m_step(m1, 3, 0, r, tk, ty, v, code);
      @(posedge clk);
      #1;
      check_eq("fn0", 32'(fn0), 32'(m0.fn));
      check_eq("lev0", 32'(lev0), 32'(m0.lev));
      check_eq("err0", 32'(if0.key_err), 32'(m0.err));
      check_eq("busy0", 32'(busy0), 32'(!m_idle(m0)));
      check_eq("fn1", 32'(fn1), 32'(m1.fn));
      check_eq("lev1", 32'(lev1), 32'(m1.lev));
      check_eq("err1", 32'(if1.key_err), 32'(m1.err));
      check_eq("busy1", 32'(busy1), 32'(!m_idle(m1)));
      check_eq("excl0", 32'((fn0 != 0) && (lev0 != 0)), 32'(0));
   endtask

   // Tick until both builds are idle, bounded.
   task automatic drain();
      int n = 0;
      while (!(m_idle(m0) && m_idle(m1)) && n < 400) begin
         step(1'b0, 1'b1, 1'b0, 1'b0, 6'h00);
         n++;
      end
      check_eq("drain_bound", 32'(n < 400), 32'(1));
   endtask

   initial begin
      int held;
      int gapped;

      m0 = '{0, 0, '0, '0, 1'b0};
      m1 = '{0, 0, '0, '0, 1'b0};
      rst = 1'b1;
      tick_ms = 1'b0;
      type_in = 1'b0;
      if0.key_valid = 1'b0;
      if0.key_code = '0;
      if1.key_valid = 1'b0;
      if1.key_code = '0;

      // Reset state
      step(1'b1, 1'b0, 1'b0, 1'b0, 6'h00);
      step(1'b1, 1'b1, 1'b0, 1'b1, 6'h21);
      check_eq("rst_fn", 32'(fn0), 32'(0));
      check_eq("rst_busy", 32'(busy0), 32'(0));

      // Function key A: held exactly 50 ticks, then 20 ticks of lockout
      step(1'b0, 1'b0, 1'b0, 1'b1, 6'h21);
      check_eq("a_fn", 32'(fn0), 32'h0002);
      held = 0;
      for (int i = 0; i < 60; i++) begin
         if (fn0 == 13'h0002) held++;
         step(1'b0, 1'b1, 1'b0, 1'b0, 6'h00);
         step(1'b0, 1'b0, 1'b0, 1'b0, 6'h00);
      end
      check_eq("a_hold_ticks", 32'(held), 32'd50);
      // 60 ticks consumed: 50 hold + 10 gap; count the remaining gap ticks
      gapped = 10;
      for (int i = 0; i < 30 && busy0; i++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0, 6'h00);
         gapped++;
      end
      check_eq("a_gap_ticks", 32'(gapped), 32'd20);
      check_eq("a_ready_after", 32'(if0.key_ready), 32'(1));

      // Character: LEV only, no error
      step(1'b0, 1'b0, 1'b0, 1'b1, 6'h1B);
      check_eq("c_lev", 32'(lev0), 32'h1B);
      check_eq("c_fn", 32'(fn0), 32'(0));
      check_eq("c_err", 32'(if0.key_err), 32'(0));
      drain();

      // Invalid function index 14
      step(1'b0, 1'b0, 1'b0, 1'b1, 6'h2E);
      check_eq("inv_err", 32'(if0.key_err), 32'(1));
      check_eq("inv_busy", 32'(busy0), 32'(0));
      step(1'b0, 1'b0, 1'b0, 1'b0, 6'h00);
      check_eq("inv_err_clr", 32'(if0.key_err), 32'(0));
      check_eq("inv_ready", 32'(if0.key_ready), 32'(1));

      // TYPE lock then release
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 6'h21);
      check_eq("type_busy", 32'(busy0), 32'(0));
      step(1'b0, 1'b0, 1'b0, 1'b1, 6'h22);
      check_eq("type_accept", 32'(fn0), 32'h0004);
      drain();

      // Tick on accept cycle not counted; short build goes straight to idle
      step(1'b0, 1'b1, 1'b0, 1'b1, 6'h2C);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 6'h00);
      check_eq("g0_idle", 32'(busy1), 32'(0));
      check_eq("g0_ready", 32'(if1.key_ready), 32'(1));
      for (int i = 0; i < 46; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 6'h00);
      check_eq("tc_still", 32'(fn0), 32'h1000);
      step(1'b0, 1'b1, 1'b0, 1'b0, 6'h00);
      check_eq("tc_release", 32'(fn0), 32'(0));
      drain();

      // Reset mid-HOLD of F
      step(1'b0, 1'b0, 1'b0, 1'b1, 6'h25);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 6'h00);
      check_eq("rh_fn", 32'(fn0), 32'h0020);
      step(1'b1, 1'b1, 1'b0, 1'b1, 6'h25);
      check_eq("rh_fn_clr", 32'(fn0), 32'(0));
      check_eq("rh_busy", 32'(busy0), 32'(0));
      step(1'b0, 1'b0, 1'b0, 1'b1, 6'h21);
      check_eq("rh_next", 32'(fn0), 32'h0002);
      drain();

      // Random traffic
      for (int i = 0; i < 6000; i++) begin
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1,
              6'($urandom_range(0, 63)));
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
